// File: rtl/mcu_bus_bridge_if.sv
// rtl/mcu_bus_bridge_if.sv - CPU, peripheral and memory bus bundle for mcu_bus_bridge.
// slave is the bridge's view; master is the view of the CPU/peripheral/memory side.
interface mcu_bus_bridge_if;
  logic        cpu_req_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_ready_out;
  logic        cpu_err_out;
  logic [2:0]  periph_addr_out;
  logic        periph_addr_valid_out;
  logic        periph_write_en_out;
  logic [7:0]  periph_data_out;
  logic [7:0]  periph_data_in;
  logic        periph_data_valid_in;
  logic        mem_req_out;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_data_out;
  logic        mem_write_en_out;
  logic [7:0]  mem_data_in;
  logic        mem_ack_in;

  modport slave (
    input  cpu_req_in, cpu_addr_in, cpu_data_in, cpu_write_en_in,
    input  periph_data_in, periph_data_valid_in, mem_data_in, mem_ack_in,
    output cpu_data_out, cpu_ready_out, cpu_err_out,
    output periph_addr_out, periph_addr_valid_out, periph_write_en_out, periph_data_out,
    output mem_req_out, mem_addr_out, mem_data_out, mem_write_en_out
  );

  modport master (
    output cpu_req_in, cpu_addr_in, cpu_data_in, cpu_write_en_in,
    output periph_data_in, periph_data_valid_in, mem_data_in, mem_ack_in,
    input  cpu_data_out, cpu_ready_out, cpu_err_out,
    input  periph_addr_out, periph_addr_valid_out, periph_write_en_out, periph_data_out,
    input  mem_req_out, mem_addr_out, mem_data_out, mem_write_en_out
  );
endinterface

// File: rtl/mcu_bus_bridge.sv
// rtl/mcu_bus_bridge.sv - Routes CPU accesses to a strobed peripheral port or a req/ack memory port.
// Optional response-wait timeout enabled by defining BUS_TIMEOUT_EN.
module mcu_bus_bridge #(
  parameter int         TIMEOUT_CYCLES = 15,
  parameter logic [3:0] PERIPH_PAGE    = 4'hF
) (
  input logic             clk_in,
  input logic             reset_n_in,
  mcu_bus_bridge_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mcu_bus_bridge: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [2:0] {IDLE, P_STROBE, P_WAIT, M_WAIT, RESP} state_t;
  state_t state;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state                     <= IDLE;
      bus.cpu_data_out          <= 8'h00;
      bus.cpu_ready_out         <= 1'b0;
      bus.cpu_err_out           <= 1'b0;
      bus.periph_addr_out       <= 3'd0;
      bus.periph_addr_valid_out <= 1'b0;
      bus.periph_write_en_out   <= 1'b0;
      bus.periph_data_out       <= 8'h00;
      bus.mem_req_out           <= 1'b0;
      bus.mem_addr_out          <= 16'h0000;
      bus.mem_data_out          <= 8'h00;
      bus.mem_write_en_out      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt                  <= 8'd0;
`endif
    end else begin
      // Pulses default low; each completion path raises them for one cycle.
      bus.cpu_ready_out         <= 1'b0;
      bus.cpu_err_out           <= 1'b0;
      bus.periph_addr_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req_in) begin
            if (bus.cpu_addr_in[15:12] == PERIPH_PAGE) begin
              bus.periph_addr_out       <= bus.cpu_addr_in[2:0];
              bus.periph_write_en_out   <= bus.cpu_write_en_in;
              bus.periph_data_out       <= bus.cpu_data_in;
              bus.periph_addr_valid_out <= 1'b1;
              state                     <= P_STROBE;
            end else begin
              bus.mem_req_out      <= 1'b1;
              bus.mem_addr_out     <= bus.cpu_addr_in;
              bus.mem_data_out     <= bus.cpu_data_in;
              bus.mem_write_en_out <= bus.cpu_write_en_in;
              state                <= M_WAIT;
            end
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
          end
        end
        P_STROBE: begin
          // The latched write qualifier doubles as the access-type memory.
          if (bus.periph_write_en_out) begin
            bus.cpu_ready_out <= 1'b1;
            state             <= RESP;
          end else begin
            state <= P_WAIT;
          end
`ifdef BUS_TIMEOUT_EN
          wait_cnt <= 8'd0;
`endif
        end
        P_WAIT: begin
          if (bus.periph_data_valid_in) begin
            bus.cpu_data_out  <= bus.periph_data_in;
            bus.cpu_ready_out <= 1'b1;
            state             <= RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            bus.cpu_data_out  <= 8'hFF;
            bus.cpu_ready_out <= 1'b1;
            bus.cpu_err_out   <= 1'b1;
            state             <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        M_WAIT: begin
          if (bus.mem_ack_in) begin
            bus.mem_req_out <= 1'b0;
            if (!bus.mem_write_en_out) bus.cpu_data_out <= bus.mem_data_in;
            bus.cpu_ready_out <= 1'b1;
            state             <= RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            bus.mem_req_out   <= 1'b0;
            bus.cpu_data_out  <= 8'hFF;
            bus.cpu_ready_out <= 1'b1;
            bus.cpu_err_out   <= 1'b1;
            state             <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// tb/tb_mcu_bus_bridge.sv - Directed table-driven bench for mcu_bus_bridge.
// Inputs change and outputs are sampled on the falling edge; t counts cycles after the accept edge.
module tb_mcu_bus_bridge;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mcu_bus_bridge_if bus ();

  mcu_bus_bridge #(.TIMEOUT_CYCLES(15), .PERIPH_PAGE(4'hF)) dut (
    .clk_in(clk),
    .reset_n_in(rstn),
    .bus(bus)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    int          delay;
    logic [7:0]  rdata;
    int          exp_lat;
    int          exp_dout;
    int          exp_strobes;
    int          exp_pidx;
    int          exp_mem_hi;
  } vec_t;

  int r_lat, r_dout, r_err, r_strobes, r_pidx, r_pwe, r_pdata;
  int r_mem_hi, r_maddr, r_mwe, r_mdata, r_maddr_changes;

  // delay: peripheral valid this many cycles after the strobe, or memory ack in the
  // delay-th cycle of mem_req_out; 0 means the target never responds.
  task automatic run_txn(input logic [15:0] a, input logic [7:0] wd, input logic w,
                         input int delay, input logic [7:0] rd, input int bound);
    int t_strobe;
    @(negedge clk);
    bus.cpu_req_in = 1'b1;
    bus.cpu_addr_in = a;
    bus.cpu_data_in = wd;
    bus.cpu_write_en_in = w;
    r_lat = -1; r_dout = -1; r_err = -1; r_strobes = 0; r_mem_hi = 0;
    r_pidx = -1; r_pwe = -1; r_pdata = -1; r_maddr = -1; r_mwe = -1; r_mdata = -1;
    r_maddr_changes = 0;
    t_strobe = -1;
    for (int t = 1; t <= bound; t++) begin
      @(negedge clk);
      if (t == 1) bus.cpu_req_in = 1'b0;
      bus.mem_ack_in = 1'b0;
      bus.periph_data_valid_in = 1'b0;
      if (bus.periph_addr_valid_out) begin
        r_strobes++;
        r_pidx = int'(bus.periph_addr_out);
        r_pwe = int'(bus.periph_write_en_out);
        r_pdata = int'(bus.periph_data_out);
        t_strobe = t;
      end
      if (bus.mem_req_out) begin
        r_mem_hi++;
        if (r_mem_hi > 1 && r_maddr != int'(bus.mem_addr_out)) r_maddr_changes++;
        r_maddr = int'(bus.mem_addr_out);
        r_mwe = int'(bus.mem_write_en_out);
        r_mdata = int'(bus.mem_data_out);
        if (delay > 0 && r_mem_hi == delay) begin
          bus.mem_ack_in = 1'b1;
          bus.mem_data_in = rd;
        end
      end
      if (delay > 0 && t_strobe > 0 && t == t_strobe + delay && !w) begin
        bus.periph_data_valid_in = 1'b1;
        bus.periph_data_in = rd;
      end
      if (bus.cpu_ready_out) begin
        r_lat = t;
        r_dout = int'(bus.cpu_data_out);
        r_err = int'(bus.cpu_err_out);
        break;
      end
    end
    bus.mem_ack_in = 1'b0;
    bus.periph_data_valid_in = 1'b0;
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.mem_ack_in = 1'b0;
      bus.periph_data_valid_in = 1'b0;
      if (bus.cpu_ready_out) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];
  int pulses;

  initial begin
    bus.cpu_req_in = 1'b0; bus.cpu_addr_in = 16'h0; bus.cpu_data_in = 8'h0;
    bus.cpu_write_en_in = 1'b0; bus.periph_data_in = 8'h0; bus.periph_data_valid_in = 1'b0;
    bus.mem_data_in = 8'h0; bus.mem_ack_in = 1'b0;

    //          addr     wdata  we  dly rdata  lat dout  stb pidx memhi
    vecs[0] = '{16'hF001, 8'h5A, 1'b1, 0, 8'h00,  2, 8'h00, 1, 1, 0};
    vecs[1] = '{16'hFAB6, 8'h00, 1'b0, 1, 8'h01,  3, 8'h01, 1, 6, 0};
    vecs[2] = '{16'h1234, 8'h00, 1'b0, 4, 8'hC3,  5, 8'hC3, 0, 0, 4};
    vecs[3] = '{16'h8000, 8'h77, 1'b1, 2, 8'hEE,  3, 8'hC3, 0, 0, 2};
    vecs[4] = '{16'hF00F, 8'h00, 1'b0, 3, 8'hA5,  5, 8'hA5, 1, 7, 0};
    vecs[5] = '{16'hF7F8, 8'h3C, 1'b1, 0, 8'h00,  2, 8'hA5, 1, 0, 0};
    vecs[6] = '{16'hEFFF, 8'h00, 1'b0, 1, 8'h3C,  2, 8'h3C, 0, 0, 1};
    vecs[7] = '{16'h2000, 8'h00, 1'b0, 15, 8'h99, 16, 8'h99, 0, 0, 15};

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.cpu_ready_out), 0);
    chk("rst_err", int'(bus.cpu_err_out), 0);
    chk("rst_dout", int'(bus.cpu_data_out), 0);
    chk("rst_pvalid", int'(bus.periph_addr_valid_out), 0);
    chk("rst_pbus", int'({bus.periph_addr_out, bus.periph_write_en_out, bus.periph_data_out}), 0);
    chk("rst_mreq", int'(bus.mem_req_out), 0);
    chk("rst_mbus", int'({bus.mem_addr_out, bus.mem_data_out, bus.mem_write_en_out}), 0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].delay, vecs[i].rdata, 40);
      chk($sformatf("v%0d_latency", i), r_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_dout", i), r_dout, vecs[i].exp_dout);
      chk($sformatf("v%0d_err", i), r_err, 0);
      chk($sformatf("v%0d_strobes", i), r_strobes, vecs[i].exp_strobes);
      chk($sformatf("v%0d_mem_hi", i), r_mem_hi, vecs[i].exp_mem_hi);
      if (vecs[i].exp_strobes > 0) begin
        chk($sformatf("v%0d_pidx", i), r_pidx, vecs[i].exp_pidx);
        chk($sformatf("v%0d_pwe", i), r_pwe, int'(vecs[i].we));
        chk($sformatf("v%0d_pdata", i), r_pdata, int'(vecs[i].wdata));
      end
      if (vecs[i].exp_mem_hi > 0) begin
        chk($sformatf("v%0d_maddr", i), r_maddr, int'(vecs[i].addr));
        chk($sformatf("v%0d_maddr_stable", i), r_maddr_changes, 0);
        chk($sformatf("v%0d_mwe", i), r_mwe, int'(vecs[i].we));
        chk($sformatf("v%0d_mdata", i), r_mdata, int'(vecs[i].wdata));
      end
    end

    // Stray responses while idle must not complete anything or disturb read data.
    @(negedge clk);
    bus.periph_data_valid_in = 1'b1; bus.periph_data_in = 8'h55;
    bus.mem_ack_in = 1'b1; bus.mem_data_in = 8'h55;
    count_ready(4, pulses);
    chk("stray_idle_ready", pulses, 0);
    chk("stray_idle_dout", int'(bus.cpu_data_out), 8'h99);
    chk("stray_idle_mreq", int'(bus.mem_req_out), 0);

    // Reset while waiting on memory abandons the access silently.
    @(negedge clk);
    bus.cpu_req_in = 1'b1; bus.cpu_addr_in = 16'h3000; bus.cpu_write_en_in = 1'b0;
    @(negedge clk);
    bus.cpu_req_in = 1'b0;
    @(negedge clk);
    chk("rstmid_mreq_before", int'(bus.mem_req_out), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_mreq_after", int'(bus.mem_req_out), 0);
    chk("rstmid_ready", int'(bus.cpu_ready_out), 0);
    rstn = 1'b1;
    count_ready(5, pulses);
    chk("rstmid_no_pulse", pulses, 0);
    run_txn(16'hF002, 8'h00, 1'b0, 1, 8'h42, 40);
    chk("post_rst_latency", r_lat, 3);
    chk("post_rst_pidx", r_pidx, 2);
    chk("post_rst_dout", r_dout, 8'h42);

`ifdef BUS_TIMEOUT_EN
    run_txn(16'h4000, 8'h00, 1'b0, 0, 8'h00, 40);
    chk("to_latency", r_lat, 16);
    chk("to_dout", r_dout, 8'hFF);
    chk("to_err", r_err, 1);
    chk("to_mem_hi", r_mem_hi, 15);
    @(negedge clk);
    chk("to_mreq_dropped", int'(bus.mem_req_out), 0);
    bus.mem_ack_in = 1'b1; bus.mem_data_in = 8'h12;
    count_ready(4, pulses);
    chk("to_stray_ack", pulses, 0);
    chk("to_stray_dout", int'(bus.cpu_data_out), 8'hFF);
    run_txn(16'hF003, 8'h00, 1'b0, 1, 8'h24, 40);
    chk("to_next_err", r_err, 0);
    chk("to_next_dout", r_dout, 8'h24);
`else
    run_txn(16'h4000, 8'h00, 1'b0, 0, 8'h00, 40);
    chk("nowait_no_ready", r_lat, -1);
    chk("nowait_mem_hi", r_mem_hi, 40);
    chk("nowait_maddr", r_maddr, 16'h4000);
    bus.mem_ack_in = 1'b1; bus.mem_data_in = 8'h6D;
    @(negedge clk);
    bus.mem_ack_in = 1'b0;
    chk("late_ack_ready", int'(bus.cpu_ready_out), 1);
    chk("late_ack_dout", int'(bus.cpu_data_out), 8'h6D);
    chk("late_ack_err", int'(bus.cpu_err_out), 0);
    chk("late_ack_mreq", int'(bus.mem_req_out), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mcu_bus_bridge.md
MCU_BUS_BRIDGE -- requirements
Module: mcu_bus_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, response-wait limit in clocks (1..255); used only with BUS_TIMEOUT_EN.
REQ-002 SHALL have parameter: PERIPH_PAGE, 4'hF, value of cpu_addr_in[15:12] selecting the peripheral port.
REQ-003 SHALL have ports (clock and reset first):
- clk_in  input  1  sole clock, all state updates on rising edge.
- reset_n_in  input  1  synchronous, active-low reset.
- cpu_req_in  input  1  CPU access request.
- cpu_addr_in  input  16  CPU byte address.
- cpu_data_in  input  8  CPU write data.
- cpu_write_en_in  input  1  1 = write, 0 = read.
- cpu_data_out  output  8  read data.
- cpu_ready_out  output  1  one-cycle completion pulse.
- cpu_err_out  output  1  timeout flag, valid with cpu_ready_out.
- periph_addr_out  output  3  peripheral register index.
- periph_addr_valid_out  output  1  one-cycle peripheral strobe.
- periph_write_en_in-side: periph_write_en_out  output  1  peripheral write qualifier.
- periph_data_out  output  8  peripheral write data.
- periph_data_in  input  8  peripheral read data.
- periph_data_valid_in  input  1  peripheral read-data valid.
- mem_req_out  output  1  memory request, level held until ack.
- mem_addr_out  output  16  memory address.
- mem_data_out  output  8  memory write data.
- mem_write_en_out  output  1  memory write qualifier.
- mem_data_in  input  8  memory read data.
- mem_ack_in  input  1  memory completion, one-cycle.

Function
REQ-004 SHALL implement states IDLE, P_STROBE, P_WAIT, M_WAIT, RESP; all outputs registered.
REQ-005 IDLE: cpu_req_in=1 SHALL latch addr/data/write_en; addr[15:12]==PERIPH_PAGE -> P_STROBE, else -> M_WAIT with mem_req_out=1 from the next cycle.
REQ-006 cpu_req_in SHALL be ignored in every state except IDLE; CPU may drop request after acceptance.
REQ-007 P_STROBE: periph_addr_valid_out=1 for exactly one cycle, periph_addr_out=addr[2:0], periph_write_en_out=latched write_en, periph_data_out=latched data; addr[11:3] ignored (aliasing).
REQ-008 Peripheral write: P_STROBE -> RESP; req sampled cycle N -> strobe cycle N+1 -> cpu_ready_out cycle N+2.
REQ-009 Peripheral read: P_STROBE -> P_WAIT; on periph_data_valid_in=1 capture periph_data_in, -> RESP; with a 1-cycle-latency peripheral cpu_ready_out at cycle N+3.
REQ-010 periph_data_valid_in outside P_WAIT SHALL be ignored.
REQ-011 M_WAIT: mem_req_out, mem_addr_out, mem_data_out, mem_write_en_out held stable until mem_ack_in=1 sampled; same edge drops mem_req_out, captures mem_data_in on reads, -> RESP.
REQ-012 mem_ack_in outside M_WAIT SHALL be ignored.
REQ-013 RESP: cpu_ready_out=1 one cycle, -> IDLE; cpu_data_out updated only on read completions and held otherwise; writes leave cpu_data_out unchanged.
REQ-014 Back-to-back: request present in IDLE the cycle after RESP SHALL be accepted; no extra idle cycle required.

Reset
REQ-015 reset_n_in=0 on a rising edge SHALL force IDLE and: cpu_data_out=8'h00, cpu_ready_out=0, cpu_err_out=0, periph_addr_out=0, periph_addr_valid_out=0, periph_write_en_out=0, periph_data_out=8'h00, mem_req_out=0, mem_addr_out=16'h0000, mem_data_out=8'h00, mem_write_en_out=0, timeout counter=0.
REQ-016 Reset mid-transaction SHALL abandon it silently: no cpu_ready_out pulse, mem_req_out low the cycle after the reset edge.

Configuration
REQ-017 Macro BUS_TIMEOUT_EN defined: 8-bit counter clears on entry to P_WAIT/M_WAIT, increments each wait cycle; reaching TIMEOUT_CYCLES -> RESP with cpu_data_out=8'hFF, cpu_err_out=1 during ready pulse, mem_req_out dropped.
REQ-018 With BUS_TIMEOUT_EN, response and timeout in the same cycle SHALL complete normally (response wins, cpu_err_out=0); cpu_err_out=0 on all non-timeout completions.
REQ-019 Macro undefined: no counter, waits indefinitely, cpu_err_out tied 0.

Verification
REQ-020 Write 8'h5A to 16'hF001 -> strobe with periph_addr_out=1, write_en=1, data 8'h5A one cycle; cpu_ready_out 2 cycles after request.
REQ-021 Read 16'hFAB6, peripheral returns 8'h01 one cycle after strobe -> periph_addr_out=6, cpu_data_out=8'h01 with cpu_ready_out 3 cycles after request.
REQ-022 Read 16'h1234, mem_ack_in after 4 cycles with 8'hC3 -> mem_req_out high 4 cycles with addr 16'h1234, cpu_data_out=8'hC3, err=0.
REQ-023 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=15, memory read never acked -> ready with data 8'hFF, err=1; later stray ack ignored.
REQ-024 reset_n_in low during M_WAIT -> mem_req_out low, no ready pulse, next request 16'hF002 completes normally.
